// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner and the downstream
// sequence-detector FSM that consumes its w output.
//   cond_state_t : 2-bit debounce FSM state encoding
//   cnt_width()  : width of the qualification counter for a given debounce length
package input_conditioner_pkg;

    // The encodings are fixed because the downstream FSM decodes the same values.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        QUAL_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        QUAL_LOW    = 2'd3
    } cond_state_t;

    function automatic int unsigned cnt_width(input int unsigned debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_sync_chain.sv
// Generic multi-flop synchronizer with asynchronous active-low clear.
//   clk   : sampling clock
//   reset : asynchronous active-low clear of every stage
//   d     : asynchronous input level
//   q     : synchronized level (last stage)
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Turns a raw asynchronous switch level into a debounced, clock-synchronous
// bit w, plus one-cycle edge pulses and a saturating glitch counter.
//   clk          : rising-edge clock
//   reset        : asynchronous active-low reset
//   raw_in       : raw asynchronous level
//   w            : debounced, synchronized level
//   w_rise       : one-cycle pulse when w goes 0->1
//   w_fall       : one-cycle pulse when w goes 1->0
//   stable       : 1 while no transition is being qualified
//   glitch_count : number of rejected transitions, saturating at all-ones
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                raw_in,
    output logic                w,
    output logic                w_rise,
    output logic                w_fall,
    output logic                stable,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam int unsigned     CW        = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam bit              ONE_CYCLE = (DEBOUNCE_CYCLES == 1);

    logic          s;
    cond_state_t   state;
    logic [CW-1:0] cnt;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_in),
        .q     (s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= STABLE_LOW;
            cnt          <= '0;
            w            <= 1'b0;
            w_rise       <= 1'b0;
            w_fall       <= 1'b0;
            stable       <= 1'b1;
            glitch_count <= '0;
        end else begin
            w_rise <= 1'b0;
            w_fall <= 1'b0;
            case (state)
                STABLE_LOW: begin
                    if (s) begin
                        // A single sample is enough to commit when the debounce length is 1.
                        if (ONE_CYCLE) begin
                            state  <= STABLE_HIGH;
                            w      <= 1'b1;
                            w_rise <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            state  <= QUAL_HIGH;
                            cnt    <= CW'(1);
                            stable <= 1'b0;
                        end
                    end
                end
                QUAL_HIGH: begin
                    if (!s) begin
                        state  <= STABLE_LOW;
                        cnt    <= '0;
                        stable <= 1'b1;
                        if (glitch_count != '1) glitch_count <= glitch_count + GLITCH_W'(1);
                    end else if (cnt == CNT_LAST) begin
                        state  <= STABLE_HIGH;
                        w      <= 1'b1;
                        w_rise <= 1'b1;
                        cnt    <= '0;
                        stable <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        if (ONE_CYCLE) begin
                            state  <= STABLE_LOW;
                            w      <= 1'b0;
                            w_fall <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            state  <= QUAL_LOW;
                            cnt    <= CW'(1);
                            stable <= 1'b0;
                        end
                    end
                end
                QUAL_LOW: begin
                    if (s) begin
                        state  <= STABLE_HIGH;
                        cnt    <= '0;
                        stable <= 1'b1;
                        if (glitch_count != '1) glitch_count <= glitch_count + GLITCH_W'(1);
                    end else if (cnt == CNT_LAST) begin
                        state  <= STABLE_LOW;
                        w      <= 1'b0;
                        w_fall <= 1'b1;
                        cnt    <= '0;
                        stable <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= STABLE_LOW;
                    w      <= 1'b0;
                    cnt    <= '0;
                    stable <= 1'b1;
                end
            endcase
        end
    end

endmodule
